// File: rtl/ov5640_dvp_capture_pkg.sv
// rtl/ov5640_dvp_capture_pkg.sv - shared types and RGB565 expansion for the DVP capture front end
package ov5640_dvp_capture_pkg;

    localparam int COLOR_W = 8;

    typedef enum logic {
        HIGH_BYTE = 1'b0,
        LOW_BYTE  = 1'b1
    } byte_phase_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb888_t;

    // Replicating the top bits keeps full-scale 565 values at 0xFF after expansion.
    function automatic rgb888_t rgb565_to_888(input logic [15:0] pix);
        rgb888_t c;
        c.r = {pix[15:11], pix[15:13]};
        c.g = {pix[10:5],  pix[10:9]};
        c.b = {pix[4:0],   pix[4:2]};
        return c;
    endfunction

endpackage

// File: rtl/ov5640_dvp_capture_if.sv
// rtl/ov5640_dvp_capture_if.sv - RGB888 pixel stream with line/frame syncs toward the YCbCr stage
interface ov5640_dvp_capture_if;
    import ov5640_dvp_capture_pkg::*;

    logic [COLOR_W-1:0] rgb_r;
    logic [COLOR_W-1:0] rgb_g;
    logic [COLOR_W-1:0] rgb_b;
    logic               rgb_hs;
    logic               rgb_vs;
    logic               rgb_de;

    modport master (output rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de);
    modport slave  (input  rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de);

endinterface

// File: rtl/ov5640_dvp_capture_frame_skip_gate.sv
// rtl/ov5640_dvp_capture_frame_skip_gate.sv - counts frame starts and opens the pixel gate after SKIP_FRAMES
module ov5640_dvp_capture_frame_skip_gate #(
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vs_n,
    input  logic i_vs_valid,
    output logic o_frame_valid
);

    localparam logic [7:0] SKIP = 8'(SKIP_FRAMES);

    logic       r_vs_prev;
    logic [7:0] r_cnt;
    logic       w_frame_start;

    assign w_frame_start = r_vs_prev & ~i_vs_n;

    // r_vs_prev stays low until the input stage holds real sensor samples, so a
    // reset released mid-frame never fakes a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev     <= 1'b0;
            r_cnt         <= 8'd0;
            o_frame_valid <= 1'b0;
        end else begin
            r_vs_prev <= i_vs_valid & i_vs_n;
            if (w_frame_start) begin
                if (r_cnt < SKIP) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                o_frame_valid <= (r_cnt == SKIP);
            end
        end
    end

endmodule

// File: rtl/ov5640_dvp_capture.sv
// rtl/ov5640_dvp_capture.sv - OV5640 DVP byte capture, RGB565 pairing and 888 expansion
module ov5640_dvp_capture
    import ov5640_dvp_capture_pkg::*;
#(
    parameter int unsigned SKIP_FRAMES    = 10,
    parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cam_vsync,
    input  logic                        cam_href,
    input  logic [7:0]                  cam_data,
    ov5640_dvp_capture_if.master        rgb,
    output logic                        frame_valid,
    output logic                        odd_byte_err
);

    logic        r_vs_d1;
    logic        r_href_d1;
    logic [7:0]  r_data_d1;
    logic        r_in_valid;
    byte_phase_t r_phase;
    logic [7:0]  r_hi_byte;
    logic [15:0] r_pix;
    logic        r_pix_strobe;
    logic        r_odd_err;
    rgb888_t     r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;

    logic        w_vs_n;
    logic        w_frame_valid;

    assign w_vs_n = r_vs_d1 ^ ~VS_ACTIVE_HIGH;

    ov5640_dvp_capture_frame_skip_gate #(
        .SKIP_FRAMES(SKIP_FRAMES)
    ) u_frame_skip_gate (
        .clk          (clk),
        .rst          (rst),
        .i_vs_n       (w_vs_n),
        .i_vs_valid   (r_in_valid),
        .o_frame_valid(w_frame_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d1      <= 1'b0;
            r_href_d1    <= 1'b0;
            r_data_d1    <= 8'd0;
            r_in_valid   <= 1'b0;
            r_phase      <= HIGH_BYTE;
            r_hi_byte    <= 8'd0;
            r_pix        <= 16'd0;
            r_pix_strobe <= 1'b0;
            r_odd_err    <= 1'b0;
            r_rgb        <= '0;
            r_hs         <= 1'b0;
            r_vs         <= 1'b0;
            r_de         <= 1'b0;
        end else begin
            r_vs_d1      <= cam_vsync;
            r_href_d1    <= cam_href;
            r_data_d1    <= cam_data;
            r_in_valid   <= 1'b1;
            r_pix_strobe <= 1'b0;

            if (r_href_d1) begin
                if (r_phase == HIGH_BYTE) begin
                    r_hi_byte <= r_data_d1;
                    r_phase   <= LOW_BYTE;
                end else begin
                    r_pix        <= {r_hi_byte, r_data_d1};
                    r_pix_strobe <= 1'b1;
                    r_phase      <= HIGH_BYTE;
                end
            end else begin
                // Line ended on an unpaired byte: drop it and realign for the next line.
                if (r_phase == LOW_BYTE) begin
                    r_odd_err <= 1'b1;
                end
                r_phase <= HIGH_BYTE;
            end

            r_de <= r_pix_strobe & w_frame_valid;
            if (r_pix_strobe & w_frame_valid) begin
                r_rgb <= rgb565_to_888(r_pix);
            end
            r_hs <= r_href_d1 & w_frame_valid;
            r_vs <= r_in_valid & w_vs_n;
        end
    end

    assign rgb.rgb_r     = r_rgb.r;
    assign rgb.rgb_g     = r_rgb.g;
    assign rgb.rgb_b     = r_rgb.b;
    assign rgb.rgb_hs    = r_hs;
    assign rgb.rgb_vs    = r_vs;
    assign rgb.rgb_de    = r_de;
    assign frame_valid   = w_frame_valid;
    assign odd_byte_err  = r_odd_err;

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// tb/tb_ov5640_dvp_capture.sv - directed self-checking bench for ov5640_dvp_capture
module tb_ov5640_dvp_capture;

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] GREY  = 24'h848284;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b1;
    logic       href = 1'b0;
    logic [7:0] data = 8'h00;
    logic       vs_inv;
    logic       fv_a, fv_b, fv_c;
    logic       err_a, err_b, err_c;

    assign vs_inv = ~vs;

    always #5 clk = ~clk;

    ov5640_dvp_capture_if if_a ();
    ov5640_dvp_capture_if if_b ();
    ov5640_dvp_capture_if if_c ();

    ov5640_dvp_capture #(.SKIP_FRAMES(2), .VS_ACTIVE_HIGH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .cam_vsync(vs), .cam_href(href), .cam_data(data),
        .rgb(if_a), .frame_valid(fv_a), .odd_byte_err(err_a)
    );

    ov5640_dvp_capture #(.SKIP_FRAMES(2), .VS_ACTIVE_HIGH(1'b0)) dut_b (
        .clk(clk), .rst(rst), .cam_vsync(vs_inv), .cam_href(href), .cam_data(data),
        .rgb(if_b), .frame_valid(fv_b), .odd_byte_err(err_b)
    );

    ov5640_dvp_capture #(.SKIP_FRAMES(0), .VS_ACTIVE_HIGH(1'b1)) dut_c (
        .clk(clk), .rst(rst), .cam_vsync(vs), .cam_href(href), .cam_data(data),
        .rgb(if_c), .frame_valid(fv_c), .odd_byte_err(err_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int de_a = 0, de_b = 0, b2b = 0, vs_mis = 0;
    logic prev_de_a = 1'b0, prev_de_b = 1'b0;
    logic [23:0] pix_log[$];
    int          pix_cyc[$];
    int          line_cyc[8];
    int          lat_ref = 0;
    int          col_base = 0;

    logic [7:0] col_line[8]  = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h84, 8'h10};
    logic [7:0] ramp_line[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (if_a.rgb_de) begin
            de_a++;
            pix_log.push_back({if_a.rgb_r, if_a.rgb_g, if_a.rgb_b});
            pix_cyc.push_back(cyc);
            if (prev_de_a) b2b++;
        end
        if (if_b.rgb_de) begin
            de_b++;
            if (prev_de_b) b2b++;
        end
        prev_de_a = if_a.rgb_de;
        prev_de_b = if_b.rgb_de;
        if (if_a.rgb_vs !== if_b.rgb_vs) vs_mis++;
    end

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        @(posedge clk);
        #1;
        vs   = v;
        href = h;
        data = d;
    endtask

    task automatic blank();
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input logic [7:0] b[8], input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, b[i]);
            line_cyc[i] = cyc;
        end
        repeat (3) idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_r"},   32'(if_a.rgb_r), 32'd0);
        check_eq({tag, "_g"},   32'(if_a.rgb_g), 32'd0);
        check_eq({tag, "_b"},   32'(if_a.rgb_b), 32'd0);
        check_eq({tag, "_hs"},  32'(if_a.rgb_hs), 32'd0);
        check_eq({tag, "_vs"},  32'(if_a.rgb_vs), 32'd0);
        check_eq({tag, "_de"},  32'(if_a.rgb_de), 32'd0);
        check_eq({tag, "_fv"},  32'(fv_a), 32'd0);
        check_eq({tag, "_err"}, 32'(err_a), 32'd0);
    endtask

    // probe: 0 none, 1 watch dut_a gate opening, 2 watch dut_c gate opening
    task automatic run_frame(input int probe, input bit colour, output int n_a, output int n_b);
        int a0, b0;
        repeat (4) blank();
        if (probe == 1) check_eq("fv_a_blank", 32'(fv_a), 32'd0);
        if (probe == 2) check_eq("fv_c_blank", 32'(fv_c), 32'd0);
        idle();
        idle();
        if (probe == 1) check_eq("fv_a_start_p1", 32'(fv_a), 32'd0);
        if (probe == 2) check_eq("fv_c_start_p1", 32'(fv_c), 32'd0);
        idle();
        if (probe == 1) check_eq("fv_a_start_p2", 32'(fv_a), 32'd1);
        if (probe == 2) check_eq("fv_c_start_p2", 32'(fv_c), 32'd1);
        a0 = de_a;
        b0 = de_b;
        col_base = pix_log.size();
        for (int l = 0; l < 4; l++) begin
            if (colour && l == 0) begin
                send_line(col_line, 8);
                lat_ref = line_cyc[1];
            end else begin
                send_line(ramp_line, 8);
            end
        end
        blank();
        n_a = de_a - a0;
        n_b = de_b - b0;
    endtask

    initial begin
        int na, nb, base, a0;

        repeat (3) blank();
        check_outputs_zero("reset");
        rst = 1'b0;

        run_frame(2, 1'b0, na, nb);
        check_eq("frame1_de", 32'(na), 32'd0);
        run_frame(0, 1'b0, na, nb);
        check_eq("frame2_de", 32'(na), 32'd0);
        run_frame(1, 1'b1, na, nb);
        check_eq("frame3_de_a", 32'(na), 32'd16);
        check_eq("frame3_de_b", 32'(nb), 32'd16);
        check_eq("pix_red",   32'(pix_log[col_base + 0]), 32'(RED));
        check_eq("pix_green", 32'(pix_log[col_base + 1]), 32'(GREEN));
        check_eq("pix_blue",  32'(pix_log[col_base + 2]), 32'(BLUE));
        check_eq("pix_grey",  32'(pix_log[col_base + 3]), 32'(GREY));
        check_eq("latency",   32'(pix_cyc[col_base] - lat_ref), 32'd3);

        check_eq("err_before_odd", 32'(err_a), 32'd0);
        repeat (4) blank();
        idle();
        idle();
        base = pix_log.size();
        send_line(col_line, 7);
        check_eq("err_after_odd", 32'(err_a), 32'd1);
        send_line(col_line, 8);
        check_eq("err_held", 32'(err_a), 32'd1);
        blank();
        check_eq("odd_frame_de", 32'(pix_log.size() - base), 32'd7);
        check_eq("odd_pix0", 32'(pix_log[base + 0]), 32'(RED));
        check_eq("odd_pix1", 32'(pix_log[base + 1]), 32'(GREEN));
        check_eq("odd_pix2", 32'(pix_log[base + 2]), 32'(BLUE));
        check_eq("realign_pix0", 32'(pix_log[base + 3]), 32'(RED));
        check_eq("realign_pix1", 32'(pix_log[base + 4]), 32'(GREEN));
        check_eq("realign_pix2", 32'(pix_log[base + 5]), 32'(BLUE));
        check_eq("realign_pix3", 32'(pix_log[base + 6]), 32'(GREY));

        repeat (4) blank();
        idle();
        idle();
        check_eq("fv_before_rst", 32'(fv_a), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, ramp_line[i]);
        rst = 1'b1;
        step(1'b0, 1'b1, ramp_line[4]);
        rst = 1'b0;
        check_outputs_zero("midline_rst");
        a0 = de_a;
        for (int i = 5; i < 8; i++) step(1'b0, 1'b1, ramp_line[i]);
        repeat (3) idle();
        send_line(ramp_line, 8);
        blank();
        check_eq("post_rst_frame_de", 32'(de_a - a0), 32'd0);

        run_frame(0, 1'b0, na, nb);
        check_eq("post_rst_skip1_de", 32'(na), 32'd0);
        run_frame(0, 1'b0, na, nb);
        check_eq("post_rst_skip2_de", 32'(na), 32'd0);
        run_frame(0, 1'b0, na, nb);
        check_eq("post_rst_gated_de_a", 32'(na), 32'd16);
        check_eq("post_rst_gated_de_b", 32'(nb), 32'd16);
        check_eq("fv_final", 32'(fv_a), 32'd1);

        repeat (4) blank();
        check_eq("no_back_to_back_de", 32'(b2b), 32'd0);
        check_eq("vs_polarity_match", 32'(vs_mis), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
